// File: rtl/pipe_pkg.sv
// pipe_pkg: default sizing and stage-action encoding shared by the pipeline register bank.
package pipe_pkg;
    localparam int DEF_WIDTH       = 32;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_STALL_AT    = 2;
    localparam int DEF_FLUSH_DEPTH = 2;
    localparam int DEF_CNT_W       = 16;
    localparam logic [1:0] ACT_LOAD   = 2'd0;
    localparam logic [1:0] ACT_HOLD   = 2'd1;
    localparam logic [1:0] ACT_BUBBLE = 2'd2;
endpackage

// File: rtl/pipe_stage_bank_if.sv
// pipe_stage_bank_if: entry/exit handshake of the pipeline register bank.
interface pipe_stage_bank_if import pipe_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    modport master (output in_data, in_valid, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, output in_ready, out_data, out_valid);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register with valid bit; payload is forced to zero whenever it is invalid.
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       act,
    input  logic [WIDTH-1:0] d,
    input  logic             v,
    output logic [WIDTH-1:0] q,
    output logic             qv
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            q  <= '0;
            qv <= 1'b0;
        end else if (act == ACT_LOAD) begin
            q  <= v ? d : '0;
            qv <= v;
        end else if (act == ACT_BUBBLE) begin
            q  <= '0;
            qv <= 1'b0;
        end
endmodule

// File: rtl/pipe_stage_bank.sv
// pipe_stage_bank: DEPTH-stage CPU pipeline register chain with hold/flush/stall and tapped stages.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush/retire performance counters.
module pipe_stage_bank import pipe_pkg::*; #(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int STALL_AT    = DEF_STALL_AT,
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    pipe_stage_bank_if.slave       io,
    input  logic                   hold,
    input  logic                   stall,
    input  logic                   flush,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic [CNT_W-1:0]       retire_cnt
);
    logic [WIDTH-1:0] q [DEPTH];
    assign io.in_ready = !hold && (!stall || flush);
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [1:0]       act;
        logic [WIDTH-1:0] d;
        logic             v;
        // Flush outranks stall; within each, the stage index picks bubble, freeze or advance.
        assign act = hold  ? ACT_HOLD :
                     flush ? (g < FLUSH_DEPTH ? ACT_BUBBLE : ACT_LOAD) :
                     stall ? (g < STALL_AT ? ACT_HOLD : g == STALL_AT ? ACT_BUBBLE : ACT_LOAD) :
                     ACT_LOAD;
        if (g == 0) begin : g_head
            assign d = io.in_data;
            assign v = io.in_valid;
        end else begin : g_body
            assign d = q[g-1];
            assign v = stage_valid[g-1];
        end
        pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
            .clk(clk), .reset(reset), .act(act), .d(d), .v(v), .q(q[g]), .qv(stage_valid[g])
        );
        assign stage_data[g*WIDTH +: WIDTH] = q[g];
    end
    assign io.out_data  = q[DEPTH-1];
    assign io.out_valid = stage_valid[DEPTH-1];
`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (!hold) begin
            if (stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            if (stage_valid[DEPTH-1] && retire_cnt != '1) retire_cnt <= retire_cnt + CNT_W'(1);
        end
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign retire_cnt = '0;
`endif
endmodule
